// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared constants for the switch operand debouncer
package sw_pkg;

    localparam int SW_W             = 8;
    localparam int NIB_W            = 4;
    localparam int DEFAULT_DEBOUNCE = 500000;
    localparam int DEFAULT_CNT_W    = 20;

    // Per-bit debounce state; SETTLING is implied whenever the counter is non-zero.
    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_SETTLING = 1'b1;

    typedef logic [NIB_W-1:0] nibble_t;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - two-flop synchroniser plus debounce counter for one switch
module debounce_bit
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw,
    output logic level,
    output logic changed,
    output logic settling
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             level_q, level_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [0:0]       state;

    assign state = (cnt_q != '0) ? ST_SETTLING : ST_STABLE;

    // Next-state: shift the synchroniser and advance, commit or abandon the count.
    always_comb begin
        s1_d      = raw;
        s2_d      = s1_q;
        level_d   = level_q;
        cnt_d     = cnt_q;
        changed_d = 1'b0;
        case (state)
            ST_STABLE: begin
                // The first mismatching edge already counts toward acceptance,
                // so a single-cycle debounce commits right here.
                if (s2_q != level_q) begin
                    if (cnt_q == CNT_LAST) begin
                        level_d   = s2_q;
                        changed_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_SETTLING: begin
                if (s2_q == level_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d   = s2_q;
                    cnt_d     = '0;
                    changed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // State registers with synchronous active-high clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            level_q   <= level_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level    = level_q;
    assign changed  = changed_q;
    assign settling = (cnt_q != '0);

endmodule

// File: rtl/sw_operand_debouncer.sv
// rtl/sw_operand_debouncer.sv - debounced operand front end for the switch summator
module sw_operand_debouncer
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [SW_W-1:0]  SW,
    output logic [NIB_W-1:0] OPA,
    output logic [NIB_W-1:0] OPB,
    output logic             UPD,
    output logic             BUSY
);

    logic [SW_W-1:0] level;
    logic [SW_W-1:0] changed;
    logic [SW_W-1:0] settling;

    // One independent debouncer per switch.
    for (genvar i = 0; i < SW_W; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .CLK      (CLK),
            .RST      (RST),
            .raw      (SW[i]),
            .level    (level[i]),
            .changed  (changed[i]),
            .settling (settling[i])
        );
    end

    // Per-bit flags are already registered, so the ORs stay glitch-free and
    // simultaneous commits collapse into one pulse.
    assign OPA  = nibble_t'(level[SW_W-1:NIB_W]);
    assign OPB  = nibble_t'(level[NIB_W-1:0]);
    assign UPD  = |changed;
    assign BUSY = |settling;

endmodule

// File: doc/sw_operand_debouncer.md
Name: sw_operand_debouncer

Overview:
- Front-end stage for the 4-bit + 4-bit switch summator.
- Takes the eight raw slide switches and passes each through a two-flop synchroniser, then a per-bit debounce counter.
- Presents clean operands: OPA = SW[7:4], OPB = SW[3:0]. The summator consumes these instead of raw switches.
- Pulses UPD whenever the debounced operand pair changes, so downstream logic can latch or refresh.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive mismatching clock edges required to accept a new switch level (10 ms at 50 MHz). Legal range is 1..2^CNT_W-1. Benches use 4.
- CNT_W, 20, width of each per-bit debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- SW   input  8  raw asynchronous switch levels; SW[7] maps to SW7.
- OPA  output 4  debounced SW[7:4], operand A.
- OPB  output 4  debounced SW[3:0], operand B.
- UPD  output 1  one-cycle pulse, high in the first cycle new OPA/OPB values are visible.
- BUSY output 1  high while any bit's counter is non-zero (a bit is settling).

Interface (already decided): one clock, CLK; reset RST is synchronous and active-high.

Behaviour:
- Reset: a rising CLK edge with RST=1 clears both sync flops, all counters, and OPA, OPB, UPD, BUSY to 0. RST overrides every other action on that edge, including mid-settling. No state survives reset.
- Synchroniser:
  - s1 <= SW; s2 <= s1.
  - Only s2 feeds the debounce logic.
  - Metastability is not modelled; a 2-cycle lag is required.
- Per-bit state machine, debounced bit d, counter c:
  - STABLE (c==0): if s2==d, stay. If s2!=d, go to SETTLING.
  - SETTLING: evaluated on each edge.
    - If s2==d: c<=0, return to STABLE. This rejects glitches and is not an error.
    - Else if c==DEBOUNCE_CYCLES-1: d<=s2, c<=0, go to STABLE.
    - Else: c<=c+1.
  - With DEBOUNCE_CYCLES=1, d updates on the first mismatching edge.
- Latency:
  - A level change on SW that precedes edge e1 and is held reaches s2 at e2.
  - d updates at edge e2+DEBOUNCE_CYCLES, i.e. DEBOUNCE_CYCLES+2 edges after sampling.
  - The N=4 bench requires an update exactly at the 6th edge.
- Chatter: any return of s2 to d resets that bit's count. Acceptance needs an unbroken run of DEBOUNCE_CYCLES mismatches. Bits are fully independent.
- UPD:
  - Registered; high for exactly one cycle, coincident with the first cycle the new OPA/OPB are visible.
  - Several bits updating on the same edge produce one pulse.
  - Updates on consecutive edges produce back-to-back pulses (UPD high for consecutive cycles).
  - UPD is never high without an OPA/OPB change.
- BUSY: the registered OR of all (c!=0). It falls in the same cycle the last settling bit commits or abandons.
- Counters never exceed DEBOUNCE_CYCLES-1. There is no wrap-around path.

Decomposition:
- Shared package/include sw_pkg:
  - SW_W=8, NIB_W=4
  - DEFAULT_DEBOUNCE=500000, DEFAULT_CNT_W=20
- Sub-module debounce_bit (ports: CLK, RST, raw, level, changed, settling):
  - Contains the 2-flop synchroniser, counter and state machine for one bit.
  - The top instantiates 8 via generate, ORs the changed outputs into UPD and the settling outputs into BUSY, and slices the levels into OPA/OPB.

Test Plan (DEBOUNCE_CYCLES=4):
1. RST=1 for 3 edges with SW=8'hFF, then release -> OPA=OPB=0, UPD=0, BUSY=0 during reset. At the 6th edge after release, OPA=4'hF and OPB=4'hF with a single UPD pulse.
2. SW=8'h00 to 8'b00010000 held -> OPA=4'b0001 exactly 6 edges later. UPD high that cycle only. BUSY high for the 3 preceding cycles. OPB unchanged at 0.
3. SW[0] high for 3 cycles then low -> OPB stays 0, UPD never asserts, BUSY returns to 0 two cycles after SW[0] falls.
4. SW from 8'b00010000 to 8'b01010010 in one step -> OPA=4'b0101 and OPB=4'b0010 on the same edge, exactly one UPD pulse.
5. SW=8'hFF from 0, RST pulsed for 1 cycle at the 3rd settling cycle -> all outputs 0 after that edge. Update occurs 6 edges after the RST edge, never earlier.
6. SW[7] toggles every 2 cycles for 20 cycles, then holds 1 -> no update during toggling. A single update and UPD pulse 6 edges after the final transition. OPA=4'b1000.
